// File: rtl/trace_axis_packer.sv
// Repacks IN_WIDTH-bit trace beats LSB-first into OUT_WIDTH-bit AXI-Stream words.
// A beat with tlast flushes the partial word (zero-padded, tkeep-masked) as the packet end.
module trace_axis_packer #(
    parameter int IN_WIDTH  = 96,
    parameter int OUT_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   S_AXIS_tvalid,
    output logic                   S_AXIS_tready,
    input  logic [IN_WIDTH-1:0]    S_AXIS_tdata,
    input  logic                   S_AXIS_tlast,
    output logic                   M_AXIS_tvalid,
    input  logic                   M_AXIS_tready,
    output logic [OUT_WIDTH-1:0]   M_AXIS_tdata,
    output logic [OUT_WIDTH/8-1:0] M_AXIS_tkeep,
    output logic                   M_AXIS_tlast,
    output logic [31:0]            packets_sent
);

    localparam int BUF_W  = IN_WIDTH + OUT_WIDTH;
    localparam int KEEP_W = OUT_WIDTH / 8;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam logic [FILL_W-1:0] OUT_FILL  = FILL_W'(OUT_WIDTH);
    localparam logic [FILL_W-1:0] IN_FILL   = FILL_W'(IN_WIDTH);
    localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};

    logic [BUF_W-1:0]  buf_r;
    logic [FILL_W-1:0] fill_r;
    logic              flush_pending_r;
    logic [31:0]       packets_sent_r;

    logic              s_tready_s;
    logic              m_tvalid_s;
    logic              m_tlast_s;
    logic              pop_s;
    logic              push_s;
    logic [FILL_W-1:0] pop_bits_s;
    logic [BUF_W-1:0]  buf_shift_s;
    logic [FILL_W-1:0] fill_shift_s;
    logic [BUF_W-1:0]  buf_next_s;
    logic [FILL_W-1:0] fill_next_s;
    logic [KEEP_W-1:0] keep_s;

    // Handshake terms come from registered state only; rst forces tready low while held.
    assign s_tready_s = ~rst & ~flush_pending_r & (fill_r <= OUT_FILL);
    assign m_tvalid_s = (fill_r >= OUT_FILL) | (flush_pending_r & (fill_r != FILL_ZERO));
    assign m_tlast_s  = flush_pending_r & (fill_r <= OUT_FILL);
    assign pop_s      = m_tvalid_s & M_AXIS_tready;
    assign push_s     = S_AXIS_tvalid & s_tready_s;
    assign pop_bits_s = (fill_r >= OUT_FILL) ? OUT_FILL : fill_r;

    // Next buffer state: pop shift first, then append the beat just above the remaining bits.
    always_comb begin
        buf_shift_s  = buf_r;
        fill_shift_s = fill_r;
        if (pop_s) begin
            buf_shift_s  = buf_r >> pop_bits_s;
            fill_shift_s = fill_r - pop_bits_s;
        end else begin
            buf_shift_s  = buf_r;
            fill_shift_s = fill_r;
        end
        buf_next_s  = buf_shift_s;
        fill_next_s = fill_shift_s;
        if (push_s) begin
            buf_next_s  = buf_shift_s | ({{OUT_WIDTH{1'b0}}, S_AXIS_tdata} << fill_shift_s);
            fill_next_s = fill_shift_s + IN_FILL;
        end else begin
            buf_next_s  = buf_shift_s;
            fill_next_s = fill_shift_s;
        end
    end

    // Byte i is valid once the buffer holds at least i+1 bytes (all ones for a full word).
    always_comb begin
        keep_s = {KEEP_W{1'b0}};
        for (int i = 0; i < KEEP_W; i++) begin
            keep_s[i] = (fill_r >= FILL_W'((i + 1) * 8));
        end
    end

    // Buffer, fill level, packet-flush flag and packet counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_r           <= {BUF_W{1'b0}};
            fill_r          <= FILL_ZERO;
            flush_pending_r <= 1'b0;
            packets_sent_r  <= 32'd0;
        end else begin
            buf_r  <= buf_next_s;
            fill_r <= fill_next_s;
            if (pop_s && m_tlast_s) begin
                flush_pending_r <= 1'b0;
                packets_sent_r  <= packets_sent_r + 32'd1;
            end else if (push_s && S_AXIS_tlast) begin
                flush_pending_r <= 1'b1;
                packets_sent_r  <= packets_sent_r;
            end else begin
                flush_pending_r <= flush_pending_r;
                packets_sent_r  <= packets_sent_r;
            end
        end
    end

    assign S_AXIS_tready = s_tready_s;
    assign M_AXIS_tvalid = m_tvalid_s;
    assign M_AXIS_tdata  = buf_r[OUT_WIDTH-1:0];
    assign M_AXIS_tkeep  = keep_s;
    assign M_AXIS_tlast  = m_tlast_s;
    assign packets_sent  = packets_sent_r;

endmodule
